ahb_req_arbiter: RTL and testbench

//  Shares one AHB manager core-side request port between NUM_REQ requesters, e.g. ifetch and ld/st.

---
 rtl/ahb_req_arbiter_pkg.sv | 26 ++
 rtl/ahb_req_arbiter_if.sv | 25 ++
 rtl/ahb_req_arbiter_rr_pick.sv | 27 ++
 rtl/ahb_req_arbiter.sv | 131 +++++++++++++
 tb/tb_ahb_req_arbiter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_req_arbiter_pkg.sv
// Shared types and helpers for the AHB request arbiter.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR4  = 3'b001;
  localparam logic [2:0] BURST_INCR8  = 3'b010;
  localparam logic [2:0] BURST_INCR16 = 3'b011;

  // Undefined burst codes are treated as a single beat.
  function automatic logic [4:0] burst_beats(input logic [2:0] burst);
    case (burst)
      BURST_SINGLE: burst_beats = 5'd1;
      BURST_INCR4:  burst_beats = 5'd4;
      BURST_INCR8:  burst_beats = 5'd8;
      BURST_INCR16: burst_beats = 5'd16;
      default:      burst_beats = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_req_arbiter_if.sv
// Core-side AHB manager request/response bundle between the arbiter and the manager.
interface ahb_req_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  m_req_read;
  logic                  m_req_write;
  logic [ADDR_WIDTH-1:0] m_req_addr;
  logic [DATA_WIDTH-1:0] m_req_wdata;
  logic [2:0]            m_req_size;
  logic [2:0]            m_req_burst;
  logic                  m_req_ready;
  logic                  m_resp_valid;
  logic [DATA_WIDTH-1:0] m_resp_rdata;

  modport master (
    output m_req_read, m_req_write, m_req_addr, m_req_wdata, m_req_size, m_req_burst,
    input  m_req_ready, m_resp_valid, m_resp_rdata
  );

  modport slave (
    input  m_req_read, m_req_write, m_req_addr, m_req_wdata, m_req_size, m_req_burst,
    output m_req_ready, m_resp_valid, m_resp_rdata
  );
endinterface

// File: rtl/ahb_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching from ptr+1, wrapping.
module rr_pick #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_gnt_valid,
  output logic [IW-1:0] o_gnt_idx
);

  logic [IW-1:0] w_j;

  always_comb begin
    o_gnt_valid = 1'b0;
    o_gnt_idx   = '0;
    w_j         = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_j = IW'((32'(i_ptr) + k) % 32'(N));
      if (!o_gnt_valid && i_req[w_j]) begin
        o_gnt_valid = 1'b1;
        o_gnt_idx   = w_j;
      end
    end
  end

endmodule

// File: rtl/ahb_req_arbiter.sv
// Round-robin arbiter sharing one AHB manager request port between NUM_REQ requesters,
// with registered request hold, read-response routing and a WAIT timeout.
module ahb_req_arbiter
  import ahb_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 2,
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int TIMEOUT    = 255,
  localparam int IW         = $clog2(NUM_REQ)
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic [NUM_REQ-1:0]            rq_valid,
  input  logic [NUM_REQ-1:0]            rq_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] rq_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] rq_wdata,
  input  logic [NUM_REQ*3-1:0]          rq_size,
  input  logic [NUM_REQ*3-1:0]          rq_burst,
  output logic [NUM_REQ-1:0]            rq_accept,
  output logic [NUM_REQ-1:0]            rq_resp_valid,
  output logic [DATA_WIDTH-1:0]         rq_rdata,
  output logic [NUM_REQ-1:0]            rq_err,
  ahb_req_arbiter_if.master             m,
  output logic                          busy,
  output logic [IW-1:0]                 owner
);

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

  arb_state_t            r_state;
  logic [IW-1:0]         r_rr_ptr;
  logic [IW-1:0]         r_owner;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [2:0]            r_size;
  logic [2:0]            r_burst;
  logic [4:0]            r_beats;
  logic [7:0]            r_tmo;
  logic                  r_seen_low;

  logic                  w_gnt_valid;
  logic [IW-1:0]         w_gnt_idx;
  logic [NUM_REQ-1:0]    w_gnt_oh;
  logic [NUM_REQ-1:0]    w_owner_oh;
  logic                  w_beat;
  logic                  w_wr_done;
  logic                  w_tmo;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .i_req       (rq_valid),
    .i_ptr       (r_rr_ptr),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_idx   (w_gnt_idx)
  );

  assign w_gnt_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_gnt_idx;
  assign w_owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;

  assign w_beat    = (r_state == ARB_WAIT) && !r_wr && m.m_resp_valid;
  assign w_wr_done = (r_state == ARB_WAIT) && r_wr && r_seen_low && m.m_req_ready;
  assign w_tmo     = (r_state == ARB_WAIT) && (r_tmo == TMO_LIMIT) && !w_beat && !w_wr_done;

  // Accept is combinational from IDLE, so it must also be masked while reset is held.
  assign rq_accept     = (r_state == ARB_IDLE && w_gnt_valid && !HRESET) ? w_gnt_oh : '0;
  assign rq_resp_valid = w_beat ? w_owner_oh : '0;
  assign rq_rdata      = w_beat ? m.m_resp_rdata : '0;
  assign rq_err        = w_tmo ? w_owner_oh : '0;

  assign m.m_req_read  = (r_state == ARB_ISSUE) && !r_wr;
  assign m.m_req_write = (r_state == ARB_ISSUE) && r_wr;
  assign m.m_req_addr  = r_addr;
  assign m.m_req_wdata = r_wdata;
  assign m.m_req_size  = r_size;
  assign m.m_req_burst = r_burst;

  assign busy  = (r_state != ARB_IDLE);
  assign owner = r_owner;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state    <= ARB_IDLE;
      r_rr_ptr   <= IW'(NUM_REQ - 1);
      r_owner    <= '0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_size     <= '0;
      r_burst    <= '0;
      r_beats    <= '0;
      r_tmo      <= '0;
      r_seen_low <= 1'b0;
    end else begin
      unique case (r_state)
        ARB_IDLE: begin
          if (w_gnt_valid) begin
            r_state  <= ARB_ISSUE;
            r_owner  <= w_gnt_idx;
            r_rr_ptr <= w_gnt_idx;
            r_wr     <= rq_write[w_gnt_idx];
            r_addr   <= rq_addr[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            r_wdata  <= rq_wdata[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            r_size   <= rq_size[w_gnt_idx*3 +: 3];
            r_burst  <= rq_burst[w_gnt_idx*3 +: 3];
            r_beats  <= burst_beats(rq_burst[w_gnt_idx*3 +: 3]);
          end
        end
        ARB_ISSUE: begin
          r_state    <= ARB_WAIT;
          r_seen_low <= 1'b0;
          r_tmo      <= '0;
        end
        ARB_WAIT: begin
          if (r_wr && !m.m_req_ready) r_seen_low <= 1'b1;
          if (w_beat) begin
            r_beats <= r_beats - 5'd1;
            r_tmo   <= '0;
            if (r_beats == 5'd1) r_state <= ARB_IDLE;
          end else if (w_wr_done || w_tmo) begin
            r_state <= ARB_IDLE;
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_req_arbiter.sv
// Directed self-checking bench for ahb_req_arbiter with two requesters.
module tb_ahb_req_arbiter;

  logic        HCLK;
  logic        HRESET;
  logic [1:0]  rq_valid, rq_write;
  logic [63:0] rq_addr, rq_wdata;
  logic [5:0]  rq_size, rq_burst;
  logic [1:0]  rq_accept, rq_resp_valid, rq_err;
  logic [31:0] rq_rdata;
  logic        busy;
  logic        owner;
  logic [111:0] w_all;

  int vec_cnt = 0;
  int err_cnt = 0;

  ahb_req_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mif ();

  ahb_req_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(255)) dut (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .rq_valid      (rq_valid),
    .rq_write      (rq_write),
    .rq_addr       (rq_addr),
    .rq_wdata      (rq_wdata),
    .rq_size       (rq_size),
    .rq_burst      (rq_burst),
    .rq_accept     (rq_accept),
    .rq_resp_valid (rq_resp_valid),
    .rq_rdata      (rq_rdata),
    .rq_err        (rq_err),
    .m             (mif),
    .busy          (busy),
    .owner         (owner)
  );

  assign w_all = {rq_accept, rq_resp_valid, rq_err, rq_rdata, mif.m_req_read, mif.m_req_write,
                  mif.m_req_addr, mif.m_req_wdata, mif.m_req_size, mif.m_req_burst, busy, owner};

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic apply_reset();
    HRESET           = 1'b1;
    rq_valid         = 2'b00;
    rq_write         = 2'b00;
    rq_addr          = '0;
    rq_wdata         = '0;
    rq_size          = {3'd2, 3'd2};
    rq_burst         = '0;
    mif.m_req_ready  = 1'b0;
    mif.m_resp_valid = 1'b0;
    mif.m_resp_rdata = '0;
    tick();
    tick();
    HRESET = 1'b0;
  endtask

  task automatic test_reset();
    HRESET           = 1'b1;
    rq_valid         = 2'b11;
    rq_write         = 2'b00;
    rq_addr          = {32'h200, 32'h100};
    rq_wdata         = {32'h2222, 32'h1111};
    rq_size          = {3'd2, 3'd2};
    rq_burst         = '0;
    mif.m_req_ready  = 1'b1;
    mif.m_resp_valid = 1'b1;
    mif.m_resp_rdata = 32'h1234;
    tick();
    tick();
    #4;
    vec_cnt++; if (w_all !== '0) begin err_cnt++; $display("FAIL reset_outputs: got %h expected 0", w_all); end
    tick();
    HRESET = 1'b0;
    mif.m_resp_valid = 1'b0;
    #4;
    vec_cnt++; if (rq_accept !== 2'b01) begin err_cnt++; $display("FAIL reset_first_accept: got %b expected 01", rq_accept); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    tick();
    #4;
    vec_cnt++; if (mif.m_req_read !== 1'b1 || mif.m_req_addr !== 32'h100) begin
      err_cnt++; $display("FAIL reset_first_issue: read %b addr %h expected 1 / 00000100", mif.m_req_read, mif.m_req_addr);
    end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_oh;
    logic [31:0] exp_addr;
    apply_reset();
    rq_valid = 2'b11;
    rq_addr  = {32'h200, 32'h100};
    for (int i = 0; i < 3; i++) begin
      exp_oh   = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (i % 2 == 0) ? 32'h100 : 32'h200;
      #4;
      vec_cnt++; if (rq_accept !== exp_oh) begin err_cnt++; $display("FAIL contention_accept%0d: got %b expected %b", i, rq_accept, exp_oh); end
      tick();
      #4;
      vec_cnt++; if (mif.m_req_read !== 1'b1 || mif.m_req_addr !== exp_addr || owner !== exp_oh[1]) begin
        err_cnt++; $display("FAIL contention_issue%0d: read %b addr %h owner %b expected 1 %h %b", i, mif.m_req_read, mif.m_req_addr, owner, exp_addr, exp_oh[1]);
      end
      tick();
      mif.m_resp_valid = 1'b1;
      mif.m_resp_rdata = 32'h1000 + 32'(i);
      #4;
      vec_cnt++; if (rq_resp_valid !== exp_oh || rq_rdata !== 32'h1000 + 32'(i)) begin
        err_cnt++; $display("FAIL contention_resp%0d: valid %b data %h expected %b %h", i, rq_resp_valid, rq_rdata, exp_oh, 32'h1000 + 32'(i));
      end
      tick();
      mif.m_resp_valid = 1'b0;
    end
  endtask

  task automatic test_burst();
    apply_reset();
    rq_valid = 2'b11;
    rq_addr  = {32'h200, 32'h40};
    rq_burst = {3'b000, 3'b001};
    #4;
    vec_cnt++; if (rq_accept !== 2'b01) begin err_cnt++; $display("FAIL burst_accept: got %b expected 01", rq_accept); end
    tick();
    #4;
    vec_cnt++; if (mif.m_req_addr !== 32'h40 || mif.m_req_burst !== 3'b001 || mif.m_req_read !== 1'b1) begin
      err_cnt++; $display("FAIL burst_issue: addr %h burst %b read %b expected 00000040 001 1", mif.m_req_addr, mif.m_req_burst, mif.m_req_read);
    end
    tick();
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin
        mif.m_resp_valid = 1'b0;
        #4;
        vec_cnt++; if (rq_resp_valid !== 2'b00 || busy !== 1'b1) begin
          err_cnt++; $display("FAIL burst_gap: valid %b busy %b expected 00 1", rq_resp_valid, busy);
        end
        tick();
      end
      mif.m_resp_valid = 1'b1;
      mif.m_resp_rdata = 32'hA + 32'(b);
      #4;
      vec_cnt++; if (rq_resp_valid !== 2'b01 || rq_rdata !== 32'hA + 32'(b) || rq_accept !== 2'b00) begin
        err_cnt++; $display("FAIL burst_beat%0d: valid %b data %h accept %b expected 01 %h 00", b, rq_resp_valid, rq_rdata, rq_accept, 32'hA + 32'(b));
      end
      tick();
    end
    mif.m_resp_rdata = 32'hEE;
    #4;
    vec_cnt++; if (rq_resp_valid !== 2'b00 || rq_rdata !== 32'h0 || rq_accept !== 2'b10) begin
      err_cnt++; $display("FAIL burst_after: valid %b data %h accept %b expected 00 0 10", rq_resp_valid, rq_rdata, rq_accept);
    end
    tick();
    mif.m_resp_valid = 1'b0;
    #4;
    vec_cnt++; if (mif.m_req_addr !== 32'h200 || owner !== 1'b1) begin
      err_cnt++; $display("FAIL burst_next_issue: addr %h owner %b expected 00000200 1", mif.m_req_addr, owner);
    end
  endtask

  task automatic test_write();
    apply_reset();
    rq_valid        = 2'b10;
    rq_write        = 2'b10;
    rq_addr         = {32'h80, 32'h0};
    rq_wdata        = {32'hDEADBEEF, 32'h0};
    mif.m_req_ready = 1'b1;
    #4;
    vec_cnt++; if (rq_accept !== 2'b10) begin err_cnt++; $display("FAIL write_accept: got %b expected 10", rq_accept); end
    tick();
    rq_valid = 2'b00;
    #4;
    vec_cnt++; if (mif.m_req_write !== 1'b1 || mif.m_req_read !== 1'b0 || mif.m_req_wdata !== 32'hDEADBEEF || mif.m_req_addr !== 32'h80) begin
      err_cnt++; $display("FAIL write_issue: wr %b rd %b wdata %h addr %h expected 1 0 deadbeef 00000080", mif.m_req_write, mif.m_req_read, mif.m_req_wdata, mif.m_req_addr);
    end
    tick();
    mif.m_resp_valid = 1'b1;
    #4;
    vec_cnt++; if (mif.m_req_write !== 1'b0 || rq_resp_valid !== 2'b00 || mif.m_req_wdata !== 32'hDEADBEEF) begin
      err_cnt++; $display("FAIL write_wait: wr %b resp %b wdata %h expected 0 00 deadbeef", mif.m_req_write, rq_resp_valid, mif.m_req_wdata);
    end
    tick();
    mif.m_resp_valid = 1'b0;
    mif.m_req_ready  = 1'b0;
    #4;
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL write_ready_high_first: busy %b expected 1", busy); end
    tick();
    tick();
    mif.m_req_ready = 1'b1;
    #4;
    vec_cnt++; if (busy !== 1'b1 || rq_err !== 2'b00) begin err_cnt++; $display("FAIL write_done_cycle: busy %b err %b expected 1 00", busy, rq_err); end
    tick();
    #4;
    vec_cnt++; if (busy !== 1'b0 || mif.m_req_write !== 1'b0) begin err_cnt++; $display("FAIL write_idle: busy %b wr %b expected 0 0", busy, mif.m_req_write); end
  endtask

  task automatic test_timeout();
    logic early;
    early = 1'b0;
    apply_reset();
    rq_valid = 2'b10;
    rq_addr  = {32'h300, 32'h0};
    #4;
    vec_cnt++; if (rq_accept !== 2'b10) begin err_cnt++; $display("FAIL timeout_accept: got %b expected 10", rq_accept); end
    tick();
    rq_valid = 2'b00;
    tick();
    for (int k = 1; k <= 255; k++) begin
      #4;
      if (rq_err !== 2'b00 || busy !== 1'b1) early = 1'b1;
      tick();
    end
    vec_cnt++; if (early !== 1'b0) begin err_cnt++; $display("FAIL timeout_early: early flag %b expected 0", early); end
    #4;
    vec_cnt++; if (rq_err !== 2'b10 || busy !== 1'b1) begin err_cnt++; $display("FAIL timeout_err: err %b busy %b expected 10 1", rq_err, busy); end
    tick();
    #4;
    vec_cnt++; if (busy !== 1'b0 || rq_err !== 2'b00) begin err_cnt++; $display("FAIL timeout_idle: busy %b err %b expected 0 00", busy, rq_err); end
  endtask

  task automatic test_midop_reset();
    apply_reset();
    rq_valid = 2'b11;
    rq_addr  = {32'h200, 32'h40};
    rq_burst = {3'b000, 3'b001};
    tick();
    tick();
    mif.m_resp_valid = 1'b1;
    mif.m_resp_rdata = 32'hA;
    tick();
    mif.m_resp_rdata = 32'hB;
    #4;
    vec_cnt++; if (rq_resp_valid !== 2'b01 || rq_rdata !== 32'hB) begin
      err_cnt++; $display("FAIL midop_beat2: valid %b data %h expected 01 0000000b", rq_resp_valid, rq_rdata);
    end
    HRESET = 1'b1;
    #1;
    vec_cnt++; if (w_all !== '0) begin err_cnt++; $display("FAIL midop_outputs: got %h expected 0", w_all); end
    tick();
    HRESET = 1'b0;
    mif.m_resp_valid = 1'b0;
    #4;
    vec_cnt++; if (rq_accept !== 2'b01) begin err_cnt++; $display("FAIL midop_first_grant: got %b expected 01", rq_accept); end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_burst();
    test_write();
    test_timeout();
    test_midop_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
